etapa_fetch: RTL and testbench

//  IF stage: owns the PC and drives the 10-bit word address of the synchronous instruction ROM (1-cycle registered read).

---
 rtl/etapa_fetch_if.sv | 27 ++
 rtl/etapa_fetch.sv | 82 ++++++++
 tb/tb_etapa_fetch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/etapa_fetch_if.sv
// rtl/etapa_fetch_if.sv - IF stage bus: ROM port, SCU/HDU control and IF/ID outputs
interface etapa_fetch_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] direccion;
  logic [DATA_W-1:0] instruccion;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc_plus1;
  logic              id_valid;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;

  modport master (
    output direccion, id_instr, id_pc_plus1, id_valid, halted, fetch_count,
    input  instruccion, stall, redirect, target
  );

  modport slave (
    input  direccion, id_instr, id_pc_plus1, id_valid, halted, fetch_count,
    output instruccion, stall, redirect, target
  );
endinterface

// File: rtl/etapa_fetch.sv
// rtl/etapa_fetch.sv - IF stage: PC, synchronous ROM addressing, IF/ID register, stall/redirect/HLT
module etapa_fetch #(
  parameter int                 ADDR_W    = 10,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 10'h000,
  parameter logic [DATA_W-1:0]  HALT_WORD = 32'h00000000,
  parameter logic [DATA_W-1:0]  NOP_WORD  = 32'h00000000,
  parameter int                 CNT_W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  etapa_fetch_if.master bus
);
  typedef enum logic {RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_next, pc_plus1;
  logic              halted, halt_hit, load_id;
  logic [CNT_W-1:0]  cnt_q;

  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign halted   = (state_q == HALT);
  // ROM data is already valid on the first cycle after reset, so only the reset cycle itself masks HLT.
  assign halt_hit = (bus.instruccion == HALT_WORD) & ~halted & ~bus.stall & ~bus.redirect & ~reset;
  assign load_id  = ~reset & ~bus.redirect & ~bus.stall & ~halted;

  // pc_next feeds the ROM address directly so that the registered read lines up with pc.
  always_comb begin
    pc_next = pc_plus1;
    if (reset)                   pc_next = RESET_PC;
    else if (bus.redirect)       pc_next = bus.target;
    else if (bus.stall)          pc_next = pc_q;
    else if (halted || halt_hit) pc_next = pc_q;
  end

  always_comb begin
    state_d = state_q;
    if (reset)             state_d = RUN;
    else if (bus.redirect) state_d = RUN;
    else if (halt_hit)     state_d = HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_next;
    end
  end

  // Bubbles keep the previous id_pc_plus1; id_valid=0 marks them.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.id_valid    <= 1'b0;
      bus.id_instr    <= NOP_WORD;
      bus.id_pc_plus1 <= '0;
    end else if (bus.redirect) begin
      bus.id_valid    <= 1'b0;
      bus.id_instr    <= NOP_WORD;
    end else if (bus.stall) begin
      bus.id_valid    <= bus.id_valid;
    end else if (halted) begin
      bus.id_valid    <= 1'b0;
      bus.id_instr    <= NOP_WORD;
    end else begin
      bus.id_valid    <= 1'b1;
      bus.id_instr    <= bus.instruccion;
      bus.id_pc_plus1 <= pc_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                      cnt_q <= '0;
    else if (load_id && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.direccion   = pc_next;
  assign bus.halted      = halted;
  assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_etapa_fetch.sv
// tb/tb_etapa_fetch.sv - vector table with scoreboard queue plus stall-over-HLT and counter saturation sequences
module tb_etapa_fetch;
  localparam logic [31:0] I0  = 32'h00210820;
  localparam logic [31:0] I3F = 32'h00431022;
  localparam int          NV  = 24;

  typedef struct {
    logic        rst, stl, rdr;
    logic [9:0]  tgt;
    logic [9:0]  e_dir;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        chk_pc;
    logic [9:0]  e_pc1;
    logic        e_halt;
    logic [3:0]  e_cnt;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] rom [0:1023];
  int          tests;
  int          fails;
  vec_t        vecs [NV];
  vec_t        sb_q [$];
  vec_t        e;

  etapa_fetch_if #(.ADDR_W(10), .DATA_W(32), .CNT_W(4)) bus ();

  etapa_fetch #(.CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) bus.instruccion <= rom[bus.direccion];

  function automatic vec_t mk(logic r, logic s, logic d, logic [9:0] t, logic [9:0] ed,
                              logic ev, logic [31:0] ei, logic cp, logic [9:0] ep,
                              logic eh, logic [3:0] ec);
    vec_t v;
    v.rst = r; v.stl = s; v.rdr = d; v.tgt = t; v.e_dir = ed; v.e_valid = ev;
    v.e_instr = ei; v.chk_pc = cp; v.e_pc1 = ep; v.e_halt = eh; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic d, input logic [9:0] t);
    @(negedge clk);
    reset = r; bus.stall = s; bus.redirect = d; bus.target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'h10000000 | i;
    for (int i = 0; i < 4; i++) rom[i] = I0;
    rom[4]    = 32'h00000000;
    rom[1023] = I3F;
    reset = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.target = '0;

    //             rst stl rdr tgt     dir     vld instr         cp pc1     h  cnt
    vecs[0]  = mk(1, 0, 0, 10'h000, 10'h000, 0, 32'h0,         1, 10'h000, 0, 0);
    vecs[1]  = mk(1, 0, 0, 10'h000, 10'h000, 0, 32'h0,         1, 10'h000, 0, 0);
    vecs[2]  = mk(0, 0, 0, 10'h000, 10'h001, 1, I0,            1, 10'h001, 0, 1);
    vecs[3]  = mk(0, 0, 0, 10'h000, 10'h002, 1, I0,            1, 10'h002, 0, 2);
    vecs[4]  = mk(0, 0, 0, 10'h000, 10'h003, 1, I0,            1, 10'h003, 0, 3);
    vecs[5]  = mk(0, 0, 0, 10'h000, 10'h004, 1, I0,            1, 10'h004, 0, 4);
    vecs[6]  = mk(0, 0, 0, 10'h000, 10'h004, 1, 32'h0,         1, 10'h005, 1, 5);
    vecs[7]  = mk(0, 0, 0, 10'h000, 10'h004, 0, 32'h0,         0, 10'h000, 1, 5);
    vecs[8]  = mk(0, 0, 0, 10'h000, 10'h004, 0, 32'h0,         0, 10'h000, 1, 5);
    vecs[9]  = mk(0, 0, 1, 10'h000, 10'h000, 0, 32'h0,         0, 10'h000, 0, 5);
    vecs[10] = mk(0, 0, 0, 10'h000, 10'h001, 1, I0,            1, 10'h001, 0, 6);
    vecs[11] = mk(0, 0, 0, 10'h000, 10'h002, 1, I0,            1, 10'h002, 0, 7);
    vecs[12] = mk(0, 1, 0, 10'h000, 10'h002, 1, I0,            1, 10'h002, 0, 7);
    vecs[13] = mk(0, 1, 0, 10'h000, 10'h002, 1, I0,            1, 10'h002, 0, 7);
    vecs[14] = mk(0, 0, 0, 10'h000, 10'h003, 1, I0,            1, 10'h003, 0, 8);
    vecs[15] = mk(0, 0, 1, 10'h020, 10'h020, 0, 32'h0,         0, 10'h000, 0, 8);
    vecs[16] = mk(0, 0, 0, 10'h000, 10'h021, 1, 32'h10000020,  1, 10'h021, 0, 9);
    vecs[17] = mk(0, 1, 1, 10'h005, 10'h005, 0, 32'h0,         0, 10'h000, 0, 9);
    vecs[18] = mk(0, 0, 0, 10'h000, 10'h006, 1, 32'h10000005,  1, 10'h006, 0, 10);
    vecs[19] = mk(0, 0, 1, 10'h3FF, 10'h3FF, 0, 32'h0,         0, 10'h000, 0, 10);
    vecs[20] = mk(0, 0, 0, 10'h000, 10'h000, 1, I3F,           1, 10'h000, 0, 11);
    vecs[21] = mk(0, 0, 0, 10'h000, 10'h001, 1, I0,            1, 10'h001, 0, 12);
    vecs[22] = mk(1, 1, 1, 10'h077, 10'h000, 0, 32'h0,         1, 10'h000, 0, 0);
    vecs[23] = mk(0, 0, 0, 10'h000, 10'h001, 1, I0,            1, 10'h001, 0, 1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; bus.stall = vecs[i].stl;
      bus.redirect = vecs[i].rdr; bus.target = vecs[i].tgt;
      #1;
      chk($sformatf("v%0d direccion", i), 32'(bus.direccion), 32'(vecs[i].e_dir));
      sb_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("v%0d id_valid", i), 32'(bus.id_valid), 32'(e.e_valid));
      chk($sformatf("v%0d id_instr", i), bus.id_instr, e.e_instr);
      if (e.chk_pc) chk($sformatf("v%0d id_pc_plus1", i), 32'(bus.id_pc_plus1), 32'(e.e_pc1));
      chk($sformatf("v%0d halted", i), 32'(bus.halted), 32'(e.e_halt));
      chk($sformatf("v%0d fetch_count", i), 32'(bus.fetch_count), 32'(e.e_cnt));
    end

    // pc=1 here; advance to the HLT at word 4, then stall across it
    for (int i = 0; i < 3; i++) step(0, 0, 0, 10'h000);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 10'h000);
      chk("stall_hlt halted", 32'(bus.halted), 32'd0);
      chk("stall_hlt direccion", 32'(bus.direccion), 32'h004);
    end
    step(0, 0, 0, 10'h000);
    chk("hlt halted", 32'(bus.halted), 32'd1);
    chk("hlt id_valid", 32'(bus.id_valid), 32'd1);
    chk("hlt id_instr", bus.id_instr, 32'h0);
    chk("hlt fetch_count", 32'(bus.fetch_count), 32'd5);

    // leave HALT and fetch enough to pin the 4-bit counter at all-ones
    step(0, 0, 1, 10'h005);
    chk("unhalt halted", 32'(bus.halted), 32'd0);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 10'h000);
    chk("sat fetch_count", 32'(bus.fetch_count), 32'd15);
    chk("sat id_valid", 32'(bus.id_valid), 32'd1);
    chk("sat id_pc_plus1", 32'(bus.id_pc_plus1), 32'h013);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
